// File: rtl/bram_stream_fetch.sv
// bram_stream_fetch: reads a run of consecutive words from a BRAM with a
// 1-cycle registered read and streams them out on a valid/ready interface.
// A 3-entry skid FIFO plus a one-deep in-flight marker absorbs the read
// latency. Reads are only issued when a FIFO slot is guaranteed.
module bram_stream_fetch #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   start_len,
  output logic                  bram_r_valid,
  output logic [ADDR_WIDTH-1:0] bram_r_addr,
  input  logic [DATA_WIDTH-1:0] bram_r_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam int DEPTH = 3;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, last_addr_reg;
  logic [ADDR_WIDTH:0]   remain_reg;
  logic                  inflight_reg, inflight_last_reg;
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic                  fifo_last [DEPTH];
  logic [1:0]            wr_ptr_reg, rd_ptr_reg, count_reg;
  logic                  accept, issue, final_issue, push, pop;

  // Pointer advance modulo the FIFO depth.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign accept      = (state_reg == IDLE) && start_valid;
  // Credit: words already buffered plus the one possibly in flight must
  // leave room for this read's data.
  assign issue       = (state_reg == ISSUE) &&
                       (({1'b0, count_reg} + {2'b0, inflight_reg}) < 3'd3);
  assign final_issue = issue && (remain_reg == (ADDR_WIDTH+1)'(1));
  assign push        = inflight_reg;
  assign pop         = out_valid && out_ready;

  assign start_ready  = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign bram_r_valid = issue;
  // Present the live address while issuing, otherwise the last one used.
  assign bram_r_addr  = issue ? addr_reg : last_addr_reg;
  assign out_valid    = (count_reg != 2'd0);
  assign out_data     = out_valid ? fifo_data[rd_ptr_reg] : '0;
  assign out_last     = out_valid ? fifo_last[rd_ptr_reg] : 1'b0;

  // Next-state selection for the run sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_valid) state_next = (start_len == '0) ? DONE : ISSUE;
      ISSUE:   if (final_issue) state_next = DRAIN;
      DRAIN:   if (pop && out_last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer, address/length counters, in-flight marker and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      last_addr_reg     <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      wr_ptr_reg        <= 2'd0;
      rd_ptr_reg        <= 2'd0;
      count_reg         <= 2'd0;
    end else begin
      state_reg         <= state_next;
      inflight_reg      <= issue;
      inflight_last_reg <= final_issue;
      if (accept) begin
        addr_reg   <= start_addr;
        remain_reg <= start_len;
      end else if (issue) begin
        addr_reg      <= addr_reg + ADDR_WIDTH'(1);
        last_addr_reg <= addr_reg;
        remain_reg    <= remain_reg - (ADDR_WIDTH+1)'(1);
      end
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: each entry captures returning read data when it is the
  // write target. Contents need no reset since out_valid gates visibility.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture one FIFO entry.
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == 2'(gi))) begin
        fifo_data[gi] <= bram_r_data;
        fifo_last[gi] <= inflight_last_reg;
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_fetch.sv
// Self-checking bench for bram_stream_fetch: a behavioural BRAM, a monitor
// that logs every handshake, and per-scenario tasks comparing the logs
// against expectations derived from the run parameters.
module tb_bram_stream_fetch;
  localparam int DW = 64;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   start_len = '0;
  logic          bram_r_valid;
  logic [AW-1:0] bram_r_addr;
  logic [DW-1:0] bram_r_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  bram_stream_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_len(start_len),
    .bram_r_valid(bram_r_valid), .bram_r_addr(bram_r_addr),
    .bram_r_data(bram_r_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural BRAM: data returned one cycle after the read enable.
  logic [DW-1:0] mem [512];
  always @(posedge clk) if (bram_r_valid) bram_r_data <= mem[bram_r_addr];

  int n_checks = 0;
  int n_fail = 0;

  // Monitor state (written only by the monitor).
  logic [AW-1:0] rd_addr_q [$];
  int            rd_cyc_q [$];
  logic [DW-1:0] pop_data_q [$];
  logic          pop_last_q [$];
  int            pop_cyc_q [$];
  int            done_cyc_q [$];
  int            acc_count = 0, acc_cyc = 0;
  int            rd_total = 0, pop_total = 0, occ_max = 0, stab_err = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] held_data;
  logic          held_last;
  bit            busy_h [int];
  bit            sr_h [int];

  // Run bookkeeping (written only by the test sequence).
  int rdy_mode = 0, mode_base = 0;
  int rd_base, pop_base, done_base, run_s;

  // Monitor: samples every cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_h[cyc] = busy;
      sr_h[cyc]   = start_ready;
      if (start_valid && start_ready) begin
        acc_count++;
        acc_cyc = cyc;
      end
      if (bram_r_valid) begin
        rd_addr_q.push_back(bram_r_addr);
        rd_cyc_q.push_back(cyc);
        rd_total++;
      end
      if (rd_total - pop_total > occ_max) occ_max = rd_total - pop_total;
      if (out_valid && out_ready) begin
        pop_data_q.push_back(out_data);
        pop_last_q.push_back(out_last);
        pop_cyc_q.push_back(cyc);
        pop_total++;
      end
      if (done) done_cyc_q.push_back(cyc);
      if (stall_prev && (!out_valid || out_data !== held_data || out_last !== held_last))
        stab_err++;
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end else begin
      stall_prev = 0;
      rd_total   = pop_total;
    end
  end

  // Consumer: 0 = always ready, 1 = stalled through s+10, 2 = random 50%.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (acc_count > mode_base) && (cyc >= acc_cyc + 11);
      default: out_ready = ($urandom & 1) != 0;
    endcase
  end

  // Reference: the i-th word of a run starting at address a.
  function automatic logic [DW-1:0] exp_word(input int a, input int i);
    return mem[(a + i) % 512];
  endfunction

  task automatic start_run(input int addr, input int len, input int mode);
    int b;
    rdy_mode  = mode;
    b         = acc_count;
    mode_base = b;
    rd_base   = rd_addr_q.size();
    pop_base  = pop_data_q.size();
    done_base = done_cyc_q.size();
    @(posedge clk); #1;
    start_valid = 1'b1;
    start_addr  = AW'(addr);
    start_len   = (AW+1)'(len);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (acc_count != b) break;
    end
    run_s = acc_cyc;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n_checks++;
    if (acc_count == b) begin
      n_fail++;
      $display("FAIL start_accept: accepts %0d required %0d", acc_count - b, 1);
    end
    for (int i = 0; i < 4000; i++) begin
      if (done_cyc_q.size() > done_base) break;
      @(negedge clk); #1;
    end
    n_checks++;
    if (done_cyc_q.size() == done_base) begin
      n_fail++;
      $display("FAIL done_timeout: done pulses 0 required 1 (addr %0d len %0d)", addr, len);
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({start_ready, bram_r_valid, busy, done, out_valid, out_last} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required %b",
               {start_ready, bram_r_valid, busy, done, out_valid, out_last}, 6'b100000);
    end
    n_checks++;
    if (bram_r_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %0d required 0", bram_r_addr);
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", out_data);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({start_ready, busy, out_valid} !== 3'b100) begin
      n_fail++; $display("FAIL idle_after_reset: got %b required 100", {start_ready, busy, out_valid});
    end
  endtask

  task automatic test_basic();
    int s, n, dc;
    start_run(4, 5, 0);
    s = run_s;
    n = pop_data_q.size() - pop_base;
    n_checks++;
    if (n != 5) begin n_fail++; $display("FAIL basic_words: got %0d required 5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      n_checks++;
      if (pop_data_q[pop_base+i] !== exp_word(4, i)) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h required %h", i, pop_data_q[pop_base+i], exp_word(4, i));
      end
      n_checks++;
      if (pop_last_q[pop_base+i] !== (i == 4)) begin
        n_fail++; $display("FAIL basic_last[%0d]: got %b required %b", i, pop_last_q[pop_base+i], i == 4);
      end
      n_checks++;
      if (pop_cyc_q[pop_base+i] != s + 3 + i) begin
        n_fail++; $display("FAIL basic_cycle[%0d]: got s+%0d required s+%0d", i, pop_cyc_q[pop_base+i] - s, 3 + i);
      end
    end
    dc = (done_cyc_q.size() > done_base) ? done_cyc_q[done_base] - s : -1;
    n_checks++;
    if (dc != 8) begin n_fail++; $display("FAIL basic_done: got s+%0d required s+8", dc); end
    n_checks++;
    if (rd_addr_q.size() - rd_base != 5) begin
      n_fail++; $display("FAIL basic_reads: got %0d required 5", rd_addr_q.size() - rd_base);
    end
    n_checks++;
    if ({busy_h[s+1], busy_h[s+8], busy_h[s+9], sr_h[s+9]} !== 4'b1101) begin
      n_fail++; $display("FAIL basic_busy: got %b required 1101", {busy_h[s+1], busy_h[s+8], busy_h[s+9], sr_h[s+9]});
    end
  endtask

  task automatic test_wrap();
    int n;
    start_run(510, 4, 0);
    n = rd_addr_q.size() - rd_base;
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL wrap_reads: got %0d required 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_checks++;
      if (rd_addr_q[rd_base+i] !== AW'((510 + i) % 512)) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, rd_addr_q[rd_base+i], (510 + i) % 512);
      end
    end
    n = pop_data_q.size() - pop_base;
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL wrap_words: got %0d required 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_checks++;
      if (pop_data_q[pop_base+i] !== exp_word(510, i)) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h required %h", i, pop_data_q[pop_base+i], exp_word(510, i));
      end
    end
  endtask

  task automatic test_backpressure();
    int s, n, early, se;
    se = stab_err;
    start_run(20, 8, 1);
    s = run_s;
    early = 0;
    for (int i = rd_base; i < rd_cyc_q.size(); i++) if (rd_cyc_q[i] <= s + 10) early++;
    n_checks++;
    if (early != 3) begin n_fail++; $display("FAIL bp_reads_stalled: got %0d required 3", early); end
    n_checks++;
    if (rd_cyc_q.size() - rd_base < 4 || rd_cyc_q[rd_base+3] != s + 12) begin
      n_fail++; $display("FAIL bp_resume: fourth read not at s+12 (reads %0d)", rd_cyc_q.size() - rd_base);
    end
    n_checks++;
    if (stab_err != se) begin n_fail++; $display("FAIL bp_stable: got %0d changes required 0", stab_err - se); end
    n = pop_data_q.size() - pop_base;
    n_checks++;
    if (n != 8) begin n_fail++; $display("FAIL bp_words: got %0d required 8", n); end
    for (int i = 0; i < 8 && i < n; i++) begin
      n_checks++;
      if (pop_data_q[pop_base+i] !== exp_word(20, i) || pop_last_q[pop_base+i] !== (i == 7)) begin
        n_fail++; $display("FAIL bp_word[%0d]: got %h/%b required %h/%b", i, pop_data_q[pop_base+i],
                           pop_last_q[pop_base+i], exp_word(20, i), i == 7);
      end
    end
  endtask

  task automatic test_random_backpressure();
    int a, n, lasts, bad, se;
    for (int k = 0; k < 512; k++) mem[k] = {$urandom, $urandom};
    a  = $urandom_range(511, 0);
    se = stab_err;
    start_run(a, 256, 2);
    n = pop_data_q.size() - pop_base;
    n_checks++;
    if (n != 256) begin n_fail++; $display("FAIL rand_words: got %0d required 256", n); end
    bad = 0; lasts = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 256 && pop_data_q[pop_base+i] !== exp_word(a, i)) bad++;
      if (pop_last_q[pop_base+i] === 1'b1) lasts++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rand_data: got %0d wrong words required 0", bad); end
    n_checks++;
    if (lasts != 1 || n == 0 || pop_last_q[pop_base+n-1] !== 1'b1) begin
      n_fail++; $display("FAIL rand_last: got %0d last flags required 1 on final word", lasts);
    end
    n_checks++;
    if (done_cyc_q.size() - done_base != 1) begin
      n_fail++; $display("FAIL rand_done: got %0d pulses required 1", done_cyc_q.size() - done_base);
    end
    n_checks++;
    if (occ_max > 3) begin n_fail++; $display("FAIL rand_occupancy: got %0d required <= 3", occ_max); end
    n_checks++;
    if (stab_err != se) begin n_fail++; $display("FAIL rand_stable: got %0d changes required 0", stab_err - se); end
  endtask

  task automatic test_zero_and_full();
    int s, n, bad, dc, a;
    start_run(7, 0, 0);
    s = run_s;
    n_checks++;
    if (rd_addr_q.size() != rd_base || pop_data_q.size() != pop_base) begin
      n_fail++; $display("FAIL zero_activity: got %0d reads %0d words required 0 0",
                         rd_addr_q.size() - rd_base, pop_data_q.size() - pop_base);
    end
    dc = (done_cyc_q.size() > done_base) ? done_cyc_q[done_base] - s : -1;
    n_checks++;
    if (dc != 1) begin n_fail++; $display("FAIL zero_done: got s+%0d required s+1", dc); end
    n_checks++;
    if ({busy_h[s+1], sr_h[s+1], sr_h[s+2]} !== 3'b101) begin
      n_fail++; $display("FAIL zero_handshake: got %b required 101", {busy_h[s+1], sr_h[s+1], sr_h[s+2]});
    end
    a = $urandom_range(511, 0);
    start_run(a, 512, 0);
    s = run_s;
    n = pop_data_q.size() - pop_base;
    n_checks++;
    if (n != 512 || rd_addr_q.size() - rd_base != 512) begin
      n_fail++; $display("FAIL full_count: got %0d words %0d reads required 512 512", n, rd_addr_q.size() - rd_base);
    end
    bad = 0;
    for (int i = 0; i < n && i < 512; i++) if (pop_data_q[pop_base+i] !== exp_word(a, i)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL full_data: got %0d wrong words required 0", bad); end
    dc = (done_cyc_q.size() > done_base) ? done_cyc_q[done_base] - s : -1;
    n_checks++;
    if (dc != 515) begin n_fail++; $display("FAIL full_done: got s+%0d required s+515", dc); end
  endtask

  task automatic test_reset_midrun();
    int b, s, n, dc, pw, dn, rd;
    bit seen;
    rdy_mode = 0;
    b = acc_count;
    pop_base = pop_data_q.size();
    seen = 0;
    @(posedge clk); #1;
    start_valid = 1'b1; start_addr = AW'(300); start_len = (AW+1)'(10);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (seen) start_valid = 1'b0;
      if (acc_count != b) seen = 1;
      if (pop_data_q.size() - pop_base >= 3) break;
    end
    start_valid = 1'b0;
    n_checks++;
    if (pop_data_q.size() - pop_base < 3) begin
      n_fail++; $display("FAIL midrun_progress: got %0d words required 3", pop_data_q.size() - pop_base);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({start_ready, bram_r_valid, busy, done, out_valid, out_last} !== 6'b100000
        || bram_r_addr !== '0 || out_data !== '0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got flags %b addr %0d data %h required 100000 0 0",
                         {start_ready, bram_r_valid, busy, done, out_valid, out_last}, bram_r_addr, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pw = pop_data_q.size(); dn = done_cyc_q.size(); rd = rd_addr_q.size();
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (pop_data_q.size() != pw || done_cyc_q.size() != dn || rd_addr_q.size() != rd) begin
      n_fail++; $display("FAIL midrun_abort: got %0d words %0d done %0d reads after reset required 0 0 0",
                         pop_data_q.size() - pw, done_cyc_q.size() - dn, rd_addr_q.size() - rd);
    end
    start_run(0, 2, 0);
    s = run_s;
    n = pop_data_q.size() - pop_base;
    n_checks++;
    if (n != 2) begin n_fail++; $display("FAIL post_reset_words: got %0d required 2", n); end
    for (int i = 0; i < 2 && i < n; i++) begin
      n_checks++;
      if (pop_data_q[pop_base+i] !== exp_word(0, i) || pop_last_q[pop_base+i] !== (i == 1)
          || pop_cyc_q[pop_base+i] != s + 3 + i) begin
        n_fail++; $display("FAIL post_reset_word[%0d]: got %h/%b at s+%0d required %h/%b at s+%0d", i,
                           pop_data_q[pop_base+i], pop_last_q[pop_base+i], pop_cyc_q[pop_base+i] - s,
                           exp_word(0, i), i == 1, 3 + i);
      end
    end
    dc = (done_cyc_q.size() > done_base) ? done_cyc_q[done_base] - s : -1;
    n_checks++;
    if (dc != 5) begin n_fail++; $display("FAIL post_reset_done: got s+%0d required s+5", dc); end
  endtask

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 64'hA000_0000_0000_0000 + 64'(k);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_random_backpressure();
    test_zero_and_full();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
